// File: rtl/aes128_decrypt_control_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes128_decrypt_control_if
// Brief    : Start/result bundle of the AES-128 decryptor; optional busy
//            flag present when AES_DEC_BUSY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface aes128_decrypt_control_if;
    logic         decrypt;
    logic [127:0] cipher_text_in;
    logic [127:0] key_in;
    logic [127:0] Dout;
    logic         done;
`ifdef AES_DEC_BUSY_EN
    logic         busy;

    modport master (output decrypt, cipher_text_in, key_in, input Dout, done, busy);
    modport slave  (input decrypt, cipher_text_in, key_in, output Dout, done, busy);
`else
    modport master (output decrypt, cipher_text_in, key_in, input Dout, done);
    modport slave  (input decrypt, cipher_text_in, key_in, output Dout, done);
`endif
endinterface
`default_nettype wire

// File: rtl/aes128_decrypt_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes128_decrypt_control
// Brief    : Multi-cycle AES-128 inverse cipher, one round step per clock,
//            40 cycles from accepted start to done. Optional macro
//            AES_DEC_BUSY_EN adds a registered busy output.
// Revision : 1.0 - initial release
// ============================================================================
module aes128_decrypt_control #(
    parameter int NR = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    aes128_decrypt_control_if.slave  bus
);
    localparam logic [3:0] C_LAST_RK = 4'(NR);
    localparam int         C_NWORDS  = 4 * (NR + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_ISR  = 3'd2,
        S_ISB  = 3'd3,
        S_ARK  = 3'd4,
        S_IMC  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    endfunction

    // Round key r lives at bits [128*r +: 128].
    function automatic logic [128*(NR+1)-1:0] key_expand(input logic [127:0] key);
        logic [32*C_NWORDS-1:0]  w;
        logic [128*(NR+1)-1:0]   rk;
        logic [31:0]             t;
        logic [7:0]              rcon;
        w    = '0;
        rk   = '0;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[32*i +: 32] = key[127-32*i -: 32];
        for (int i = 4; i < C_NWORDS; i++) begin
            t = w[32*(i-1) +: 32];
            if (i % 4 == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end
            w[32*i +: 32] = w[32*(i-4) +: 32] ^ t;
        end
        for (int r = 0; r <= NR; r++)
            rk[128*r +: 128] = {w[32*(4*r) +: 32],   w[32*(4*r+1) +: 32],
                                w[32*(4*r+2) +: 32], w[32*(4*r+3) +: 32]};
        return rk;
    endfunction

    // Byte n of a state is bits [127-8n -: 8]; byte 4c+r is row r, column c.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [31:0]  col;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            col = s[127-32*c -: 32];
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = gf_mul(8'h0e, col[31-8*r -: 8])
                                     ^ gf_mul(8'h0b, col[31-8*((r+1)%4) -: 8])
                                     ^ gf_mul(8'h0d, col[31-8*((r+2)%4) -: 8])
                                     ^ gf_mul(8'h09, col[31-8*((r+3)%4) -: 8]);
        end
        return o;
    endfunction

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [127:0]           r_ct;
    logic [127:0]           r_key;
    logic [127:0]           r_st;
    logic [127:0]           r_isr;
    logic [127:0]           r_isb;
    logic [127:0]           r_ark;
    logic [127:0]           r_dout;
    logic                   r_done;

    logic [128*(NR+1)-1:0]  w_rk;
    logic [127:0]           w_rk_sel;
    logic [127:0]           w_ark;

    assign w_rk     = key_expand(r_key);
    assign w_rk_sel = w_rk[128*r_cnt +: 128];
    assign w_ark    = r_isb ^ w_rk_sel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ct    <= '0;
            r_key   <= '0;
            r_st    <= '0;
            r_isr   <= '0;
            r_isb   <= '0;
            r_ark   <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.decrypt) begin
                        r_ct    <= bus.cipher_text_in;
                        r_key   <= bus.key_in;
                        r_cnt   <= C_LAST_RK;
                        r_done  <= 1'b0;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_st    <= r_ct ^ w_rk_sel;
                    r_cnt   <= C_LAST_RK - 4'd1;
                    r_state <= S_ISR;
                end
                S_ISR: begin
                    r_isr   <= inv_shift_rows(r_st);
                    r_state <= S_ISB;
                end
                S_ISB: begin
                    r_isb   <= inv_sub_bytes(r_isr);
                    r_state <= S_ARK;
                end
                S_ARK: begin
                    if (r_cnt != 4'd0) begin
                        r_ark   <= w_ark;
                        r_state <= S_IMC;
                    end else begin
                        r_dout  <= w_ark;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_IMC: begin
                    r_st    <= inv_mix_columns(r_ark);
                    r_cnt   <= r_cnt - 4'd1;
                    r_state <= S_ISR;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Dout = r_dout;
    assign bus.done = r_done;

`ifdef AES_DEC_BUSY_EN
    logic r_busy;

    // Falls on the same edge that raises done, so the two never overlap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else if ((r_state == S_IDLE || r_state == S_DONE) && bus.decrypt) begin
            r_busy <= 1'b1;
        end else if (r_state == S_ARK && r_cnt == 4'd0) begin
            r_busy <= 1'b0;
        end
    end

    assign bus.busy = r_busy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes128_decrypt_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aes128_decrypt_control
// Brief    : Scoreboard bench for aes128_decrypt_control; random vectors come
//            from a table-driven forward AES model. Busy checks under
//            AES_DEC_BUSY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes128_decrypt_control;
    localparam logic [127:0] C_KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam int           C_LAT   = 40;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [127:0] pt;
        int           due;
        string        name;
    } exp_t;
    exp_t sb_q[$];

    aes128_decrypt_control_if dif ();

    aes128_decrypt_control #(.NR(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model: forward AES-128 ----------------
    logic [7:0] sbox_t [256];

    function automatic int gmul(input int a, input int b);
        int p = 0;
        int x = a;
        int y = b;
        for (int i = 0; i < 8; i++) begin
            if ((y & 1) != 0) p = p ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] b;
        logic [7:0] s;
        logic [7:0] aff;
        aff = 8'h63;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) b = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ aff[i];
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   ks [176];
        logic [7:0]   s  [16];
        logic [7:0]   t  [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc;
        logic [7:0]   x;
        logic [127:0] out;
        for (int j = 0; j < 16; j++) begin
            ks[j] = key[127-8*j -: 8];
            s[j]  = pt[127-8*j -: 8] ^ ks[j];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = ks[i-4+j];
            if (i % 16 == 0) begin
                x      = tmp[0];
                tmp[0] = sbox_t[tmp[1]] ^ rc;
                tmp[1] = sbox_t[tmp[2]];
                tmp[2] = sbox_t[tmp[3]];
                tmp[3] = sbox_t[x];
                rc     = 8'(gmul(int'(rc), 2));
            end
            for (int j = 0; j < 4; j++) ks[i+j] = ks[i-16+j] ^ tmp[j];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int j = 0; j < 16; j++)
                t[j] = sbox_t[s[4*(((j/4)+(j%4))%4) + (j%4)]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rnd < 10)
                        s[4*c+r] = 8'(gmul(int'(t[4*c+r]), 2) ^ gmul(int'(t[4*c+(r+1)%4]), 3)
                                      ^ int'(t[4*c+(r+2)%4]) ^ int'(t[4*c+(r+3)%4]));
                    else
                        s[4*c+r] = t[4*c+r];
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ ks[16*rnd+j];
        end
        for (int j = 0; j < 16; j++) out[127-8*j -: 8] = s[j];
        return out;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic start_run(input logic [127:0] key, input logic [127:0] ct,
                             input logic [127:0] pt, input string name);
        dif.key_in         = key;
        dif.cipher_text_in = ct;
        dif.decrypt        = 1'b1;
        sb_q.push_back('{pt: pt, due: cyc + 1 + C_LAT, name: name});
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding after %0d cycles", sb_q.size(), budget);
            sb_q.delete();
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_done = 1'b0;
`ifdef AES_DEC_BUSY_EN
    logic prev_busy = 1'b0;
    int   busy_len  = 0;
`endif

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            prev_done = 1'b0;
`ifdef AES_DEC_BUSY_EN
            prev_busy = 1'b0;
            busy_len  = 0;
`endif
        end else begin
            if (dif.done && !prev_done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done rose at cycle %0d with nothing expected", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check128({e.name, "_dout"}, dif.Dout, e.pt);
                    check_int({e.name, "_latency"}, cyc, e.due);
                end
            end
            prev_done = dif.done;
`ifdef AES_DEC_BUSY_EN
            if (dif.busy && !prev_busy) check_int("busy_rise_done_low", int'(dif.done), 0);
            if (dif.busy) begin
                busy_len++;
            end else if (prev_busy) begin
                check_int("busy_length", busy_len, C_LAT);
                check_int("busy_fall_done_high", int'(dif.done), 1);
                busy_len = 0;
            end
            prev_busy = dif.busy;
`endif
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int c;
        logic [127:0] key;
        logic [127:0] pt;

        dif.decrypt        = 1'b0;
        dif.cipher_text_in = '0;
        dif.key_in         = '0;
        build_sbox();

        repeat (2) @(negedge clock);
        check128("reset_dout", dif.Dout, '0);
        check_int("reset_done", int'(dif.done), 0);
`ifdef AES_DEC_BUSY_EN
        check_int("reset_busy", int'(dif.busy), 0);
`endif
        reset = 1'b0;

        // FIPS-197 Appendix B, single-cycle start pulse
        @(negedge clock);
        start_run(C_KEY_B, C_CT_B, C_PT_B, "fips_b");
        @(negedge clock);
        dif.decrypt = 1'b0;
        wait_drain(60);
        repeat (3) @(negedge clock);
        check_int("done_level", int'(dif.done), 1);
        check128("dout_hold", dif.Dout, C_PT_B);

        // FIPS-197 Appendix C.1
        @(negedge clock);
        start_run(C_KEY_C, C_CT_C, C_PT_C, "fips_c1");
        @(negedge clock);
        dif.decrypt = 1'b0;
        wait_drain(60);

        // A second start while busy must be ignored
        @(negedge clock);
        start_run(C_KEY_B, C_CT_B, C_PT_B, "busy_ignore");
        @(negedge clock);
        dif.decrypt = 1'b0;
        repeat (8) @(negedge clock);
        dif.key_in         = C_KEY_C;
        dif.cipher_text_in = C_CT_C;
        dif.decrypt        = 1'b1;
        @(negedge clock);
        dif.decrypt = 1'b0;
        wait_drain(60);

        // Back-to-back: decrypt held high across two runs
        @(negedge clock);
        c = cyc;
        start_run(C_KEY_C, C_CT_C, C_PT_C, "b2b_first");
        sb_q.push_back('{pt: C_PT_C, due: c + 2 * (C_LAT + 1), name: "b2b_second"});
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (cyc == c + C_LAT + 1) check_int("b2b_done_high", int'(dif.done), 1);
            if (cyc == c + C_LAT + 2) begin
                check_int("b2b_done_drop", int'(dif.done), 0);
                dif.decrypt = 1'b0;
                break;
            end
        end
        dif.decrypt = 1'b0;
        wait_drain(60);

        // Asynchronous reset in the middle of a run
        @(negedge clock);
        start_run(C_KEY_B, C_CT_B, C_PT_B, "aborted");
        @(negedge clock);
        dif.decrypt = 1'b0;
        repeat (19) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check128("midrun_reset_dout", dif.Dout, '0);
        check_int("midrun_reset_done", int'(dif.done), 0);
`ifdef AES_DEC_BUSY_EN
        check_int("midrun_reset_busy", int'(dif.busy), 0);
`endif
        sb_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        start_run(C_KEY_B, C_CT_B, C_PT_B, "after_reset");
        @(negedge clock);
        dif.decrypt = 1'b0;
        wait_drain(60);

        // Round trip on random key/plaintext pairs; inputs scrambled after accept
        for (int n = 0; n < 100; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clock);
            start_run(key, aes_encrypt(key, pt), pt, "roundtrip");
            @(negedge clock);
            dif.decrypt        = 1'b0;
            dif.key_in         = {$urandom, $urandom, $urandom, $urandom};
            dif.cipher_text_in = {$urandom, $urandom, $urandom, $urandom};
            wait_drain(60);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
